// File: rtl/cache_pkg.sv
// Shared types and line-geometry constants for the cache refill controller.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    RD   = 2'd2,
    DONE = 2'd3
  } refill_state_t;

  localparam int DEF_ADDR_W         = 32;
  localparam int DEF_DATA_W         = 32;
  localparam int DEF_WORDS_PER_LINE = 4;

  function automatic int line_bytes(input int data_w, input int words);
    return words * (data_w / 8);
  endfunction

  function automatic int off_bits(input int data_w, input int words);
    return $clog2(line_bytes(data_w, words));
  endfunction

  localparam int LINE_BYTES = line_bytes(DEF_DATA_W, DEF_WORDS_PER_LINE);
  localparam int OFF_BITS   = off_bits(DEF_DATA_W, DEF_WORDS_PER_LINE);

endpackage

// File: rtl/cache_refill_ctrl_if.sv
// Miss/fill handshake toward the cache and request/ack bus toward main memory.
interface cache_refill_ctrl_if
  import cache_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE
);

  logic                               miss_valid;
  logic                               miss_ready;
  logic [ADDR_W-1:0]                  miss_addr;
  logic                               victim_dirty;
  logic [ADDR_W-1:0]                  victim_addr;
  logic [DATA_W*WORDS_PER_LINE-1:0]   victim_data;
  logic                               fill_valid;
  logic [ADDR_W-1:0]                  fill_addr;
  logic [DATA_W*WORDS_PER_LINE-1:0]   fill_data;
  logic                               busy;

  logic                               mem_req;
  logic                               mem_we;
  logic [ADDR_W-1:0]                  mem_addr;
  logic [DATA_W-1:0]                  mem_wdata;
  logic                               mem_ack;
  logic [DATA_W-1:0]                  mem_rdata;

  // Controller side
  modport master (
    input  miss_valid, miss_addr, victim_dirty, victim_addr, victim_data,
    input  mem_ack, mem_rdata,
    output miss_ready, fill_valid, fill_addr, fill_data, busy,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  // Cache plus memory side
  modport slave (
    output miss_valid, miss_addr, victim_dirty, victim_addr, victim_data,
    output mem_ack, mem_rdata,
    input  miss_ready, fill_valid, fill_addr, fill_data, busy,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/cache_refill_ctrl.sv
// Miss-service engine: optional dirty-victim writeback, then word-by-word line
// read, then a single-cycle fill pulse back to the cache.
//
//   state | meaning
//   IDLE  | waiting for a miss, miss_ready high
//   WB    | writing the victim line, one word per mem_ack
//   RD    | reading the missing line, one word per mem_ack
//   DONE  | fill_valid pulse, line and address on fill_*
module cache_refill_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
  input  logic                 clk,
  input  logic                 reset,
  cache_refill_ctrl_if.master  bus
);

  localparam int BYTES_PER_WORD = DATA_W / 8;
  localparam int LINE_OFF       = off_bits(DATA_W, WORDS_PER_LINE);
  localparam int IDX_W          = $clog2(WORDS_PER_LINE);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(WORDS_PER_LINE - 1);
  localparam logic [ADDR_W-1:0] BASE_MASK = {ADDR_W{1'b1}} << LINE_OFF;

  refill_state_t     state_q;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  idx_d;
  logic [DATA_W-1:0] line_q [WORDS_PER_LINE];
  logic [ADDR_W-1:0] miss_base_q;
  logic [ADDR_W-1:0] victim_base_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              fill_valid_q;
  logic              last_word;
  logic [ADDR_W-1:0] miss_base_in;
  logic [ADDR_W-1:0] victim_base_in;
  logic [DATA_W*WORDS_PER_LINE-1:0] line_flat;

  // Word addresses stay inside the line because the base is aligned and idx
  // never exceeds the last word.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [IDX_W-1:0]  idx);
    return base + ADDR_W'(idx) * ADDR_W'(BYTES_PER_WORD);
  endfunction

  assign idx_d          = idx_q + 1'b1;
  assign last_word      = (idx_q == LAST_IDX);
  assign miss_base_in   = bus.miss_addr & BASE_MASK;
  assign victim_base_in = bus.victim_addr & BASE_MASK;

  // Sequencer: state, word index, line buffer and all memory-side outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      for (int i = 0; i < WORDS_PER_LINE; i++) line_q[i] <= '0;
      miss_base_q   <= '0;
      victim_base_q <= '0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      fill_valid_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.miss_valid) begin
            miss_base_q   <= miss_base_in;
            victim_base_q <= victim_base_in;
            for (int i = 0; i < WORDS_PER_LINE; i++)
              line_q[i] <= bus.victim_data[i*DATA_W +: DATA_W];
            idx_q     <= '0;
            mem_req_q <= 1'b1;
            if (bus.victim_dirty) begin
              state_q     <= WB;
              mem_we_q    <= 1'b1;
              mem_addr_q  <= victim_base_in;
              mem_wdata_q <= bus.victim_data[DATA_W-1:0];
            end else begin
              state_q    <= RD;
              mem_we_q   <= 1'b0;
              mem_addr_q <= miss_base_in;
            end
          end
        end
        WB: begin
          if (bus.mem_ack) begin
            idx_q <= idx_d;
            if (last_word) begin
              state_q    <= RD;
              mem_we_q   <= 1'b0;
              mem_addr_q <= miss_base_q;
            end else begin
              mem_addr_q  <= word_addr(victim_base_q, idx_d);
              mem_wdata_q <= line_q[idx_d];
            end
          end
        end
        RD: begin
          if (bus.mem_ack) begin
            line_q[idx_q] <= bus.mem_rdata;
            idx_q         <= idx_d;
            if (last_word) begin
              state_q      <= DONE;
              mem_req_q    <= 1'b0;
              fill_valid_q <= 1'b1;
            end else begin
              mem_addr_q <= word_addr(miss_base_q, idx_d);
            end
          end
        end
        DONE: begin
          fill_valid_q <= 1'b0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Flatten the line buffer, word 0 in the LSBs
  always_comb begin
    line_flat = '0;
    for (int i = 0; i < WORDS_PER_LINE; i++)
      line_flat[i*DATA_W +: DATA_W] = line_q[i];
  end

  assign bus.miss_ready = (state_q == IDLE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.fill_valid = fill_valid_q;
  assign bus.fill_addr  = miss_base_q;
  assign bus.fill_data  = line_flat;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;

endmodule

// File: doc/cache_refill_ctrl.md
# cache_refill_ctrl

Miss-service engine sitting directly downstream of `TopCache`, between the cache and backing main memory. On a cache miss it accepts the line address and the victim line. If the victim is dirty, it writes the victim back word by word. It then reads the requested line word by word over a narrow request/acknowledge memory bus and returns the assembled line to the cache in one `fill_valid` pulse.

## Interface
- `ADDR_W`, 32, byte-address width
- `DATA_W`, 32, memory word width in bits; multiple of 8
- `WORDS_PER_LINE`, 4, words per cache line; power of two, ≥2
- `clk` in 1: single clock; all state changes on its rising edge
- `reset` in 1: asynchronous, active-high
- `miss_valid` in 1: cache requests miss service
- `miss_ready` out 1: high in IDLE only
- `miss_addr` in ADDR_W: any byte address in the missing line; low offset bits ignored
- `victim_dirty` in 1: victim line must be written back first
- `victim_addr` in ADDR_W: any byte address in the victim line; low offset bits ignored
- `victim_data` in DATA_W*WORDS_PER_LINE: victim line; word 0 in the LSBs
- `fill_valid` out 1: one-cycle pulse; refilled line is available
- `fill_addr` out ADDR_W: line-aligned refill address
- `fill_data` out DATA_W*WORDS_PER_LINE: refilled line; word 0 in the LSBs
- `busy` out 1: not in IDLE
- `mem_req` out 1: memory access request
- `mem_we` out 1: 1 = write, 0 = read
- `mem_addr` out ADDR_W: word byte address
- `mem_wdata` out DATA_W: write data
- `mem_ack` in 1: memory completes the current access in this cycle
- `mem_rdata` in DATA_W: read data; valid when `mem_ack`=1 and `mem_we`=0

## Operation
- States: IDLE, WB, RD, DONE.
- Line alignment: `OFF_BITS` = log2(WORDS_PER_LINE·DATA_W/8). Aligned base = address with `OFF_BITS` LSBs cleared. Word address = base + idx·(DATA_W/8); it never carries outside the line.
- IDLE: on an edge with `miss_valid`&`miss_ready`, register the aligned miss and victim bases, load `victim_data` into the line buffer, and clear the word index. Go to WB if `victim_dirty`, else RD.
- WB: `mem_req`=1, `mem_we`=1, `mem_addr`=victim base + word offset, `mem_wdata`=buffer[idx]. On `mem_ack`, increment idx. On ack of the last word, idx wraps to 0 and the state goes to RD.
- RD: `mem_req`=1, `mem_we`=0, `mem_addr`=miss base + word offset. On `mem_ack`, write `mem_rdata` into buffer[idx] and increment idx. On ack of the last word, idx wraps to 0 and the state goes to DONE.
- DONE: `fill_valid`=1 for exactly one cycle; then go to IDLE.
- `fill_addr` and `fill_data` are the registered miss base and buffer contents. Both hold stable until the next acceptance.
- `mem_req` stays high across consecutive words in a phase; address and write data change only on the edge after an ack.
- `mem_ack` sampled while `mem_req`=0 is ignored.
- `miss_valid` outside IDLE is ignored; it is neither queued nor errored.
- Inputs other than `mem_ack`/`mem_rdata` are don't-care after acceptance.

## Timing
- Reset values (asynchronous, immediate): state IDLE, idx 0, buffer 0. Outputs: `miss_ready`=1, `busy`=0, `fill_valid`=0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `fill_addr`=0, `fill_data`=0.
- Reset mid-operation: abort. `mem_req` drops in the same cycle, the partial line is discarded, and no `fill_valid` is produced.
- Acceptance edge E: `mem_req` rises in cycle E+1.
- With zero-wait memory (`mem_ack` always 1):
  - clean miss: `fill_valid` in cycle E+1+N
  - dirty miss: `fill_valid` in cycle E+1+2N
  - `miss_ready` returns in the following cycle
  - N = WORDS_PER_LINE
- Each memory wait cycle (`mem_ack`=0 while `mem_req`=1) adds exactly one cycle of latency.
- All outputs are registered or decoded from registered state. There is no combinational path from inputs to outputs.

## Structure
- Package `cache_pkg` holds:
  - `refill_state_t` enum {IDLE, WB, RD, DONE}
  - the `OFF_BITS` and line-byte constants derived from the parameters
- Single module; no sub-module is needed. The line buffer is an internal register array indexed by the log2(WORDS_PER_LINE)-bit word counter.

## Test plan
- Clean miss: `miss_addr`=0x0000_1234, `mem_ack` tied 1, memory word at address A = A^0xA5A5_A5A5.
  - Expect reads at 0x1230, 0x1234, 0x1238, 0x123C.
  - Expect `fill_valid` at E+5 with `fill_addr`=0x1230 and the four XOR words in LSB-first order.
- Dirty miss: `victim_addr`=0x8008, `victim_data`={4,3,2,1}, `miss_addr`=0x40.
  - Expect writes 1@0x8000, 2@0x8004, 3@0x8008, 4@0x800C, then reads at 0x40–0x4C.
  - Expect `fill_valid` at E+9.
- Wait states: `mem_ack` low for 3 cycles before each ack on a clean miss.
  - Expect `mem_addr` stable during each wait and `fill_valid` at E+17.
- Reset mid-RD after 2 acks.
  - Expect `mem_req`=0 immediately, `miss_ready`=1 and `fill_valid`=0 throughout.
  - A new miss then completes normally.
- `miss_valid` held high continuously: expect exactly one acceptance per `miss_ready` cycle.
  - `mem_ack` pulsed while `mem_req`=0 has no effect on idx or buffer.
